sd_clk_gen: RTL and testbench
=============================

// Module: sd_clk_gen
// PURPOSE
//  Fabric-side SD card clock generator, driven from the single PLL system clock.
//  Produces the SD clock as a registered output, with one-cycle rise/fall strobes for cmd/dat logic.
//  Supports an identification-speed divisor and a transfer-speed divisor.
//  Speed changes are glitch-free and use a req/ack handshake.
//  The clock can be stopped safely, low phase only, when the host side stalls.
// PARAMETERS
//  INIT_DIV  60  identification divisor, even, >=2 (24 MHz/60 = 400 kHz)
//  FAST_DIV  2   transfer divisor, even, >=2 (24 MHz/2 = 12 MHz)
//  CNT_W     8   half-period counter width; must hold max(DIV)/2-1
// PORTS
//  clk_i         in   1  system clock (PLL clkout, 24 MHz)
//  rst_i         in   1  synchronous reset, active-high
//  en_i          in   1  level: 1 = run SD clock, 0 = park it low
//  fast_req_i    in   1  level: requested speed, 1 = FAST_DIV, 0 = INIT_DIV
//  fast_o        out  1  speed currently in effect
//  switch_ack_o  out  1  one-cycle pulse when fast_o changes
//  sd_clk_o      out  1  SD card clock, registered
//  rise_o        out  1  one-cycle pulse in the first cycle sd_clk_o is high
//  fall_o        out  1  one-cycle pulse in the first cycle sd_clk_o is low
//  idle_o        out  1  1 = clock parked low, counter cleared
// BEHAVIOUR
//  Reset values:
//   - sd_clk_o=0, rise_o=0, fall_o=0, fast_o=0, switch_ack_o=0, idle_o=1, cnt=0.
//  Reset mid-operation:
//   - sd_clk_o drops to 0 in the next cycle; no fall_o pulse is issued.
//   - A pending speed request is discarded.
//  Half period:
//   - H = DIV/2, where DIV is the divisor selected by fast_o.
//   - cnt counts 0..H-1; at cnt==H-1, sd_clk_o toggles and cnt returns to 0.
//   - sd_clk_o holds each level for exactly H clk_i cycles, giving a 50% duty cycle.
//  Strobes:
//   - rise_o and fall_o are registered together with sd_clk_o, coincident with the new level.
//   - Never both high in the same cycle; never asserted while idle.
//  States: IDLE, LOW, HIGH.
//   - IDLE: sd_clk_o=0, cnt held at 0, idle_o=1. Goes to LOW when en_i=1, with idle_o=0 the next cycle.
//   - LOW: counts H cycles, then goes to HIGH with a rise_o pulse. The first low phase after IDLE is a full H cycles.
//   - HIGH: counts H cycles, then goes to LOW with a fall_o pulse.
//  Stopping:
//   - en_i is sampled only at the end of a LOW phase (cnt==H-1).
//   - If en_i=0 there, go to IDLE instead of HIGH. No rise_o pulse; sd_clk_o stays 0.
//   - en_i falling during HIGH never truncates the high phase.
//   - The low phase before parking is always a full H cycles.
//  Speed switch:
//   - Triggered when fast_req_i != fast_o.
//   - While in IDLE: fast_o updates the next cycle.
//   - Otherwise: fast_o updates in the cycle the HIGH->LOW transition occurs (with fall_o).
//   - The new H governs that LOW phase onward, so no phase is ever shorter than min(H_old, H_new).
//   - switch_ack_o pulses in the same cycle fast_o changes.
//  Simultaneous events:
//   - A pending switch and en_i=0 at the same LOW end: park first. The switch then applies in IDLE the following cycle.
//   - A request reverted before it is applied produces no ack.
// STRUCTURE
//  Shared header sd_defs.vh holds:
//   - SD_INIT_DIV and SD_FAST_DIV defaults
//   - the state encodings IDLE=2'd0, LOW=2'd1, HIGH=2'd2
//  Single module with no sub-module; a 2-bit state register plus the CNT_W-bit counter.
// TESTING
//  - Reset, en_i=1, fast_req_i=0: sd_clk_o period is 60 cycles, high 30/low 30. First rise_o comes 30 cycles after the first non-idle cycle.
//  - fast_req_i=1 while HIGH at 400 kHz: ack coincides with fall_o. The next phases are 1 cycle each (12 MHz); no phase is < 1 cycle.
//  - en_i=0 mid-HIGH at FAST: the high phase completes, then one full low phase. idle_o=1, sd_clk_o stays 0 for 100 cycles, no strobes.
//  - Toggle fast_req_i while idle: fast_o and switch_ack_o change the next cycle. Re-enable gives a full low phase before the first rise_o.
//  - rst_i asserted at cnt=10 of a HIGH phase: the next cycle shows all outputs at reset values and fast_o=0 despite fast_req_i=1.
//  - Pulse fast_req_i 1 then 0 within one HIGH phase: no switch_ack_o, and the period is unchanged.

Source files
------------

// File: rtl/sd_clk_gen_pkg.sv
// Shared definitions for the SD card clock generator.
//   state_e      : FSM state encoding (IDLE=0, LOW=1, HIGH=2)
//   SD_INIT_DIV  : default identification-speed divisor (24 MHz / 60 = 400 kHz)
//   SD_FAST_DIV  : default transfer-speed divisor (24 MHz / 2 = 12 MHz)
package sd_clk_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    localparam int SD_INIT_DIV = 60;
    localparam int SD_FAST_DIV = 2;

endpackage

// File: rtl/sd_clk_gen.sv
// SD card clock generator running from the system clock.
// Produces a registered 50% duty SD clock with rise/fall strobes, two
// selectable divisors with a glitch-free req/ack speed switch, and a
// low-phase-only park when en_i drops.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   en_i          1 = run SD clock, 0 = park it low
//   fast_req_i    requested speed, 1 = FAST_DIV, 0 = INIT_DIV
//   fast_o        speed currently in effect
//   switch_ack_o  one-cycle pulse when fast_o changes
//   sd_clk_o      SD card clock, registered
//   rise_o        pulse in the first cycle sd_clk_o is high
//   fall_o        pulse in the first cycle sd_clk_o is low
//   idle_o        1 = clock parked low, counter cleared
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | clock parked low, counter held at 0; speed switches apply here
// LOW   | low half-period; en_i sampled at its last cycle
// HIGH  | high half-period; pending speed switch applies at its end
module sd_clk_gen
    import sd_clk_gen_pkg::*;
#(
    parameter int INIT_DIV = SD_INIT_DIV,
    parameter int FAST_DIV = SD_FAST_DIV,
    parameter int CNT_W    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic fast_req_i,
    output logic fast_o,
    output logic switch_ack_o,
    output logic sd_clk_o,
    output logic rise_o,
    output logic fall_o,
    output logic idle_o
);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV / 2 - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sd_clk_q, sd_clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             fast_q, fast_d;
    logic             ack_q, ack_d;

    logic [CNT_W-1:0] half_last;
    logic             phase_end;
    logic             switch_pend;

    // The half-period limit follows fast_q, so a switch committed together
    // with a phase start already governs that whole phase.
    assign half_last   = fast_q ? FAST_LAST : INIT_LAST;
    assign phase_end   = (cnt_q == half_last);
    assign switch_pend = (fast_req_i != fast_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sd_clk_d = sd_clk_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        fast_d   = fast_q;
        ack_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                sd_clk_d = 1'b0;
                if (switch_pend) begin
                    fast_d = fast_req_i;
                    ack_d  = 1'b1;
                end
                if (en_i) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (en_i) begin
                        state_d  = ST_HIGH;
                        sd_clk_d = 1'b1;
                        rise_d   = 1'b1;
                    end else begin
                        // Park; any pending switch is picked up in IDLE.
                        state_d  = ST_IDLE;
                        sd_clk_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    cnt_d    = '0;
                    state_d  = ST_LOW;
                    sd_clk_d = 1'b0;
                    fall_d   = 1'b1;
                    if (switch_pend) begin
                        fast_d = fast_req_i;
                        ack_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                sd_clk_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sd_clk_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            fast_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sd_clk_q <= sd_clk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            fast_q   <= fast_d;
            ack_q    <= ack_d;
        end
    end

    assign fast_o       = fast_q;
    assign switch_ack_o = ack_q;
    assign sd_clk_o     = sd_clk_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign idle_o       = (state_q == ST_IDLE);

endmodule

// File: tb/tb_sd_clk_gen.sv
// Bench for sd_clk_gen: directed scenarios followed by random stimulus, all
// compared every cycle against a phase-level reference model.
module tb_sd_clk_gen;

    localparam int INIT_DIV = 60;
    localparam int FAST_DIV = 2;

    logic clk = 1'b0;
    logic rst, en, req;
    logic fast_o, switch_ack_o, sd_clk_o, rise_o, fall_o, idle_o;

    int checks = 0;
    int errors = 0;
    int ack_seen = 0;

    // Reference model: running flag, current level, cycles left in phase.
    bit m_run, m_lvl, m_fast, m_rise, m_fall, m_ack;
    int m_left;

    always #5 clk = ~clk;

    sd_clk_gen #(.INIT_DIV(INIT_DIV), .FAST_DIV(FAST_DIV), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .fast_req_i  (req),
        .fast_o      (fast_o),
        .switch_ack_o(switch_ack_o),
        .sd_clk_o    (sd_clk_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .idle_o      (idle_o)
    );

    function automatic int half(input bit f);
        return f ? FAST_DIV / 2 : INIT_DIV / 2;
    endfunction

    task automatic model_update();
        m_rise = 0;
        m_fall = 0;
        m_ack  = 0;
        if (rst) begin
            m_run  = 0;
            m_lvl  = 0;
            m_fast = 0;
            m_left = 0;
        end else if (!m_run) begin
            if (req != m_fast) begin
                m_fast = req;
                m_ack  = 1;
            end
            if (en) begin
                m_run  = 1;
                m_lvl  = 0;
                m_left = half(m_fast);
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (!m_lvl) begin
                    if (en) begin
                        m_lvl  = 1;
                        m_rise = 1;
                        m_left = half(m_fast);
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    m_lvl  = 0;
                    m_fall = 1;
                    if (req != m_fast) begin
                        m_fast = req;
                        m_ack  = 1;
                    end
                    m_left = half(m_fast);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("sd_clk", sd_clk_o, m_run && m_lvl);
        check("rise", rise_o, m_rise);
        check("fall", fall_o, m_fall);
        check("fast", fast_o, m_fast);
        check("ack", switch_ack_o, m_ack);
        check("idle", idle_o, !m_run);
        if (switch_ack_o === 1'b1) ack_seen++;
    endtask

    // which: 0 = rise_o, 1 = fall_o, 2 = switch_ack_o
    task automatic run_until(input int which, input int limit, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            step();
            n++;
            hit = (which == 0) ? rise_o : (which == 1) ? fall_o : switch_ack_o;
        end
        check_int("event_within_bound", int'(hit), 1);
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b1;
        en  = 1'b0;
        req = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_sd_clk", sd_clk_o, 1'b0);
        check("rst_idle", idle_o, 1'b1);
        check("rst_fast", fast_o, 1'b0);

        // Slow run: first low phase full, 30/30 duty
        rst = 1'b0;
        en  = 1'b1;
        step();
        check("first_nonidle", idle_o, 1'b0);
        run_until(0, 100, n);
        check_int("first_rise_delay", n, INIT_DIV / 2);
        run_until(1, 100, n);
        check_int("slow_high_len", n, INIT_DIV / 2);
        run_until(0, 100, n);
        check_int("slow_low_len", n, INIT_DIV / 2);

        // Switch to fast while HIGH: ack with fall, then 1-cycle phases
        repeat (3) step();
        req = 1'b1;
        run_until(2, 100, n);
        check("ack_with_fall", fall_o, 1'b1);
        check("fast_after_ack", fast_o, 1'b1);
        step();
        check("fast_rise", rise_o, 1'b1);
        step();
        check("fast_fall", fall_o, 1'b1);

        // Park from HIGH at fast speed
        step();
        if (sd_clk_o !== 1'b1) step();
        en = 1'b0;
        repeat (2) step();
        check("parked", idle_o, 1'b1);
        bad = 0;
        repeat (100) begin
            step();
            if (sd_clk_o !== 1'b0 || rise_o !== 1'b0 || fall_o !== 1'b0 || idle_o !== 1'b1) bad++;
        end
        check_int("park_quiet", bad, 0);

        // Speed change while idle, then re-enable at slow speed
        req = 1'b0;
        step();
        check("idle_switch_fast", fast_o, 1'b0);
        check("idle_switch_ack", switch_ack_o, 1'b1);
        step();
        check("idle_ack_single", switch_ack_o, 1'b0);
        en = 1'b1;
        step();
        run_until(0, 100, n);
        check_int("reenable_low_len", n, INIT_DIV / 2);

        // Reset at cnt=10 of HIGH with fast request pending
        repeat (10) step();
        rst = 1'b1;
        req = 1'b1;
        step();
        check("midrst_sd_clk", sd_clk_o, 1'b0);
        check("midrst_fall", fall_o, 1'b0);
        check("midrst_fast", fast_o, 1'b0);
        check("midrst_idle", idle_o, 1'b1);
        rst = 1'b0;
        req = 1'b0;

        // Request pulsed and reverted within one HIGH phase
        step();
        run_until(0, 100, n);
        ack_seen = 0;
        repeat (5) step();
        req = 1'b1;
        repeat (5) step();
        req = 1'b0;
        run_until(1, 100, n);
        check_int("pulse_high_len", n + 10, INIT_DIV / 2);
        run_until(0, 100, n);
        check_int("pulse_low_len", n, INIT_DIV / 2);
        check_int("pulse_no_ack", ack_seen, 0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            rst = 1'b0;
            if (r < 25) req = ~req;
            else if (r < 40) en = ~en;
            else if (r < 42) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
